// File: rtl/hadamard_collector.sv
// Collects the 4-lane complex result of the fixed-latency hadamard stage, buffers whole
// vectors and streams them out one complex SFP sample per cycle with an upstream credit.
module hadamard_collector #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int LATENCY     = 5,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [formatWidth*4-1:0] vec_real,
  input  logic [formatWidth*4-1:0] vec_imag,
  output logic                     can_start,
  output logic [formatWidth-1:0]   out_real,
  output logic [formatWidth-1:0]   out_imag,
  output logic [1:0]               out_lane,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow
);

  localparam int VW = formatWidth * 4;
  localparam int EW = 2 * VW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  generate
    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        formatWidth != 1 + expWidth + sigWidth) begin : g_bad_params
      $error("hadamard_collector: illegal parameter set");
    end
  endgenerate

  function automatic logic [formatWidth-1:0] lane_sel(input logic [VW-1:0] v,
                                                       input logic [1:0]    l);
    logic [formatWidth-1:0] r;
    case (l)
      2'd0:    r = v[formatWidth*1-1 : 0];
      2'd1:    r = v[formatWidth*2-1 : formatWidth*1];
      2'd2:    r = v[formatWidth*3-1 : formatWidth*2];
      2'd3:    r = v[formatWidth*4-1 : formatWidth*3];
      default: r = {formatWidth{1'b0}};
    endcase
    return r;
  endfunction

  logic [LATENCY-1:0] trk_r;
  logic [IW-1:0]      inflight_r;
  logic [IW-1:0]      inflight_nxt_s;
  logic [EW-1:0]      mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic [1:0]         lane_r;
  logic               overflow_r;
  logic               cap_s;
  logic               valid_s;
  logic               full_s;
  logic               pop_s;
  logic               wr_s;
  logic               drop_s;
  logic [EW-1:0]      head_s;
  logic [SW-1:0]      credit_sum_s;

  assign cap_s   = trk_r[LATENCY-1];
  assign valid_s = (count_r != {CW{1'b0}});
  assign full_s  = (count_r == DEPTH_C);
  assign pop_s   = valid_s & out_ready & (lane_r == 2'd3);
  // A full FIFO still accepts the capture when the head leaves in the same cycle.
  assign wr_s    = cap_s & (~full_s | pop_s);
  assign drop_s  = cap_s & full_s & ~pop_s;

  // Latency tracker: one bit per start marching towards the capture point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_r <= {LATENCY{1'b0}};
    end else begin
      trk_r[0] <= start;
      for (int i = 1; i < LATENCY; i++) begin
        trk_r[i] <= trk_r[i-1];
      end
    end
  end

  // Next in-flight count from start/capture activity.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({start, cap_s})
      2'b10:   inflight_nxt_s = inflight_r + IW'(1'b1);
      2'b01:   inflight_nxt_s = inflight_r - IW'(1'b1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Next FIFO occupancy from write/pop activity.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: pointers, counters, serialiser lane and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= {IW{1'b0}};
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      lane_r     <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      inflight_r <= inflight_nxt_s;
      count_r    <= count_nxt_s;
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      if (valid_s && out_ready) begin
        lane_r <= lane_r + 2'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Vector storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else if (wr_s) begin
      mem_r[wr_ptr_r] <= {vec_imag, vec_real};
    end
  end

  // Credit ignores a same-cycle pop, so it can only under-promise.
  assign credit_sum_s = SW'(count_r) + SW'(inflight_r);
  assign can_start    = (credit_sum_s < DEPTH_S);

  assign head_s    = mem_r[rd_ptr_r];
  assign out_real  = lane_sel(head_s[VW-1:0], lane_r);
  assign out_imag  = lane_sel(head_s[EW-1:VW], lane_r);
  assign out_lane  = lane_r;
  assign out_last  = (lane_r == 2'd3);
  assign out_valid = valid_s;
  assign overflow  = overflow_r;

endmodule
